// File: rtl/icache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  function automatic int tag_w(input int index_bits, input int offset_bits);
    return 32 - index_bits - offset_bits;
  endfunction

  function automatic int words(input int offset_bits);
    return 1 << (offset_bits - 2);
  endfunction

  function automatic int block_w(input int offset_bits);
    return 8 << offset_bits;
  endfunction

  localparam int TAG_W   = tag_w(3, 4);
  localparam int WORDS   = words(4);
  localparam int BLOCK_W = block_w(4);

  localparam logic [31:0] NOP_WORD = 32'h0;

endpackage

// File: rtl/icache_line_store.sv
// Data, tag and valid arrays of the cache. Valid bits reset asynchronously;
// tags and data are plain storage written one line at a time.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 25,
  parameter int BLOCK_BITS = 128
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [INDEX_BITS-1:0] i_rd_idx,
  output logic                  o_rd_valid,
  output logic [TAG_BITS-1:0]   o_rd_tag,
  output logic [BLOCK_BITS-1:0] o_rd_data,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_idx,
  input  logic [TAG_BITS-1:0]   i_wr_tag,
  input  logic [BLOCK_BITS-1:0] i_wr_data,
  input  logic                  i_inv_all
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [BLOCK_BITS-1:0] r_data [LINES];

  // A line written in the same edge as invalidate-all survives: the write comes last.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else begin
      if (i_inv_all) r_valid <= '0;
      if (i_wr_en)   r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped read-only instruction cache: 0-cycle hits, block refill on miss,
// saturating hit/miss profiling counters.
module icache_controller
  import icache_pkg::*;
#(
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 4,
  parameter int CNT_W       = 16
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [31:0]                   PC_ADDRESS,
  input  logic                          INVALIDATE,
  output logic [31:0]                   INSTRUCTION,
  output logic                          CPU_BUSYWAIT,
  output logic                          MEM_READ,
  output logic [31-OFFSET_BITS:0]       MEM_ADDRESS,
  input  logic [(8<<OFFSET_BITS)-1:0]   MEM_READDATA,
  input  logic                          MEM_BUSYWAIT,
  output logic [CNT_W-1:0]              HIT_COUNT,
  output logic [CNT_W-1:0]              MISS_COUNT
);

  localparam int TAG_BITS   = tag_w(INDEX_BITS, OFFSET_BITS);
  localparam int BLOCK_BITS = block_w(OFFSET_BITS);
  localparam int WSEL_BITS  = OFFSET_BITS - 2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t r_state, w_next_state;

  logic                    r_mem_read;
  logic [31-OFFSET_BITS:0] r_mem_addr;
  logic                    r_first;
  logic [BLOCK_BITS-1:0]   r_block;
  logic [CNT_W-1:0]        r_hit_cnt, r_miss_cnt;

  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_idx;
  logic [WSEL_BITS-1:0]  w_word;
  logic                  w_unused_pc;
  logic                  w_rd_valid;
  logic [TAG_BITS-1:0]   w_rd_tag;
  logic [BLOCK_BITS-1:0] w_rd_data;
  logic [BLOCK_BITS-1:0] w_shifted;
  logic                  w_hit, w_miss_start, w_capture, w_wr_en;

  assign w_tag       = PC_ADDRESS[31:OFFSET_BITS+INDEX_BITS];
  assign w_idx       = PC_ADDRESS[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign w_word      = PC_ADDRESS[OFFSET_BITS-1:2];
  assign w_unused_pc = ^PC_ADDRESS[1:0];

  icache_line_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .BLOCK_BITS (BLOCK_BITS)
  ) u_store (
    .i_clk      (CLK),
    .i_rst_n    (RESET),
    .i_rd_idx   (w_idx),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (r_mem_addr[INDEX_BITS-1:0]),
    .i_wr_tag   (r_mem_addr[31-OFFSET_BITS:INDEX_BITS]),
    .i_wr_data  (r_block),
    .i_inv_all  (INVALIDATE)
  );

  // A pending invalidate turns what would be a hit into a miss.
  assign w_hit        = (r_state == IDLE) && w_rd_valid && (w_rd_tag == w_tag) && !INVALIDATE;
  assign w_miss_start = (r_state == IDLE) && !w_hit;
  assign w_capture    = (r_state == icache_pkg::MEM_READ) && !r_first && !MEM_BUSYWAIT;
  assign w_shifted    = w_rd_data >> {w_word, 5'd0};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_wr_en      = 1'b0;
    CPU_BUSYWAIT = 1'b1;
    INSTRUCTION  = NOP_WORD;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          CPU_BUSYWAIT = 1'b0;
          INSTRUCTION  = w_shifted[31:0];
        end else begin
          w_next_state = icache_pkg::MEM_READ;
        end
      end
      icache_pkg::MEM_READ: begin
        if (w_capture) w_next_state = UPDATE;
      end
      UPDATE: begin
        w_wr_en      = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // r_first masks MEM_BUSYWAIT during the first MEM_READ cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_mem_read <= 1'b0;
      r_mem_addr <= '0;
      r_first    <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit) r_hit_cnt <= sat_inc(r_hit_cnt);
      if (w_miss_start) begin
        r_miss_cnt <= sat_inc(r_miss_cnt);
        r_mem_read <= 1'b1;
        r_mem_addr <= {w_tag, w_idx};
        r_first    <= 1'b1;
      end else if (r_state == icache_pkg::MEM_READ) begin
        r_first <= 1'b0;
        if (w_capture) r_mem_read <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_capture) r_block <= MEM_READDATA;
  end

  assign MEM_READ    = r_mem_read;
  assign MEM_ADDRESS = r_mem_addr;
  assign HIT_COUNT   = r_hit_cnt;
  assign MISS_COUNT  = r_miss_cnt;

endmodule

// File: tb/tb_icache_controller.sv
// Directed bench for icache_controller with a fixed-latency block memory model.
module tb_icache_controller;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [31:0]   PC_ADDRESS;
  logic          INVALIDATE;
  logic [31:0]   INSTRUCTION;
  logic          CPU_BUSYWAIT;
  logic          MEM_READ;
  logic [27:0]   MEM_ADDRESS;
  logic [127:0]  MEM_READDATA;
  logic          MEM_BUSYWAIT;
  logic [15:0]   HIT_COUNT;
  logic [15:0]   MISS_COUNT;

  int n_checks = 0;
  int n_errors = 0;
  int mem_cnt  = 0;

  icache_controller #(
    .INDEX_BITS  (3),
    .OFFSET_BITS (4),
    .CNT_W       (16)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC_ADDRESS   (PC_ADDRESS),
    .INVALIDATE   (INVALIDATE),
    .INSTRUCTION  (INSTRUCTION),
    .CPU_BUSYWAIT (CPU_BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT),
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT)
  );

  always #5 CLK = ~CLK;

  // Instruction stored at byte address a is {16'hC0DE, a[15:0]}.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Block memory: busy for the first 5 sampled cycles of a request, then ready.
  initial MEM_BUSYWAIT = 1'b1;
  always @(negedge CLK) begin
    if (MEM_READ) begin
      MEM_BUSYWAIT = (mem_cnt < 5);
      mem_cnt      = mem_cnt + 1;
    end else begin
      mem_cnt      = 0;
      MEM_BUSYWAIT = 1'b1;
    end
    for (int w = 0; w < 4; w++)
      MEM_READDATA[32*w +: 32] = mem_word({MEM_ADDRESS, 4'b0000} + 32'(4 * w));
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (CPU_BUSYWAIT && n < 100) begin
      @(negedge CLK); #1;
      n++;
    end
    check_eq({tag, "_done"}, 32'(CPU_BUSYWAIT), 32'd0);
  endtask

  task automatic access(input string tag, input logic [31:0] pc, input logic exp_miss,
                        input logic [27:0] exp_blk);
    @(negedge CLK);
    PC_ADDRESS = pc;
    #1;
    check_eq({tag, "_busy"}, 32'(CPU_BUSYWAIT), 32'(exp_miss));
    if (exp_miss) begin
      check_eq({tag, "_nop"}, INSTRUCTION, 32'h0);
      @(negedge CLK); #1;
      check_eq({tag, "_memrd"}, 32'(MEM_READ), 32'd1);
      check_eq({tag, "_maddr"}, 32'(MEM_ADDRESS), 32'(exp_blk));
      wait_done(tag);
    end else begin
      check_eq({tag, "_memrd0"}, 32'(MEM_READ), 32'd0);
    end
    check_eq({tag, "_instr"}, INSTRUCTION, mem_word(pc & 32'hFFFF_FFFC));
  endtask

  initial begin
    RESET      = 1'b0;
    PC_ADDRESS = 32'h0;
    INVALIDATE = 1'b0;
    #1;
    check_eq("rst_memrd", 32'(MEM_READ), 32'd0);
    check_eq("rst_maddr", 32'(MEM_ADDRESS), 32'd0);
    check_eq("rst_hit", 32'(HIT_COUNT), 32'd0);
    check_eq("rst_miss", 32'(MISS_COUNT), 32'd0);
    check_eq("rst_busy", 32'(CPU_BUSYWAIT), 32'd1);
    check_eq("rst_instr", INSTRUCTION, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;

    // Test 1: cold miss at 0x00
    access("t1", 32'h00, 1'b1, 28'h0);
    check_eq("t1_instr_k", INSTRUCTION, 32'hC0DE_0000);
    check_eq("t1_miss", 32'(MISS_COUNT), 32'd1);
    check_eq("t1_hit", 32'(HIT_COUNT), 32'd0);

    // Test 2: remaining words of the block hit
    access("t2a", 32'h04, 1'b0, 28'h0);
    access("t2b", 32'h08, 1'b0, 28'h0);
    access("t2c", 32'h0C, 1'b0, 28'h0);
    check_eq("t2_instr_k", INSTRUCTION, 32'hC0DE_000C);
    @(negedge CLK); #1;
    check_eq("t2_hit", 32'(HIT_COUNT), 32'd4);
    check_eq("t2_memrd", 32'(MEM_READ), 32'd0);

    // Test 3: conflict on index 0
    access("t3a", 32'h80, 1'b1, 28'h8);
    check_eq("t3a_instr_k", INSTRUCTION, 32'hC0DE_0080);
    access("t3b", 32'h00, 1'b1, 28'h0);
    check_eq("t3_miss", 32'(MISS_COUNT), 32'd3);
    check_eq("t3_hit", 32'(HIT_COUNT), 32'd6);

    // Test 4: invalidate wins over a hit
    @(negedge CLK);
    PC_ADDRESS = 32'h04;
    INVALIDATE = 1'b1;
    #1;
    check_eq("t4_busy", 32'(CPU_BUSYWAIT), 32'd1);
    check_eq("t4_instr", INSTRUCTION, 32'h0);
    check_eq("t4_hit_before", 32'(HIT_COUNT), 32'd7);
    @(negedge CLK);
    INVALIDATE = 1'b0;
    #1;
    check_eq("t4_hit", 32'(HIT_COUNT), 32'd7);
    check_eq("t4_miss", 32'(MISS_COUNT), 32'd4);
    check_eq("t4_memrd", 32'(MEM_READ), 32'd1);
    wait_done("t4");
    check_eq("t4_word", INSTRUCTION, 32'hC0DE_0004);

    // Test 5: invalidate during MEM_READ does not abort the refill
    @(negedge CLK);
    PC_ADDRESS = 32'h10;
    #1;
    check_eq("t5_busy", 32'(CPU_BUSYWAIT), 32'd1);
    @(negedge CLK); #1;
    check_eq("t5_memrd", 32'(MEM_READ), 32'd1);
    check_eq("t5_maddr", 32'(MEM_ADDRESS), 32'h1);
    check_eq("t5_miss", 32'(MISS_COUNT), 32'd5);
    INVALIDATE = 1'b1;
    @(negedge CLK);
    INVALIDATE = 1'b0;
    #1;
    check_eq("t5_still_rd", 32'(MEM_READ), 32'd1);
    wait_done("t5");
    check_eq("t5_word", INSTRUCTION, 32'hC0DE_0010);
    access("t5b", 32'h00, 1'b1, 28'h0);
    check_eq("t5b_miss", 32'(MISS_COUNT), 32'd6);
    access("t5c", 32'h14, 1'b0, 28'h0);

    // Test 6: async reset in the middle of a refill
    @(negedge CLK);
    PC_ADDRESS = 32'h20;
    #1;
    check_eq("t6_hit_pre", 32'(HIT_COUNT), 32'd11);
    @(negedge CLK); #1;
    check_eq("t6_memrd", 32'(MEM_READ), 32'd1);
    check_eq("t6_miss_pre", 32'(MISS_COUNT), 32'd7);
    #1;
    RESET = 1'b0;
    #1;
    check_eq("t6_rst_memrd", 32'(MEM_READ), 32'd0);
    check_eq("t6_rst_maddr", 32'(MEM_ADDRESS), 32'd0);
    check_eq("t6_rst_hit", 32'(HIT_COUNT), 32'd0);
    check_eq("t6_rst_miss", 32'(MISS_COUNT), 32'd0);
    check_eq("t6_rst_busy", 32'(CPU_BUSYWAIT), 32'd1);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check_eq("t6_busy", 32'(CPU_BUSYWAIT), 32'd1);
    @(negedge CLK); #1;
    check_eq("t6_memrd2", 32'(MEM_READ), 32'd1);
    check_eq("t6_maddr", 32'(MEM_ADDRESS), 32'h2);
    check_eq("t6_miss", 32'(MISS_COUNT), 32'd1);
    wait_done("t6");
    check_eq("t6_word", INSTRUCTION, 32'hC0DE_0020);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
